block_former: RTL and testbench
===============================

BLOCK_FORMER -- requirements
Module: block_former

Interface
REQ-001 Parameter MAX_WIDTH, default 640, SHALL set the maximum supported line width in pixels; it must be a multiple of 8.
REQ-002 clk_in  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 d_qual  input  1  SHALL qualify d_in for one cycle per sample.
REQ-005 d_in  input  8  SHALL carry colour-converted samples, pixel-interleaved Y,Cb,Cr, raster order.
REQ-006 line_width  input  32  SHALL be the picture width in pixels.
REQ-007 pic_height  input  32  SHALL be the picture height in lines.
REQ-008 dimensions_valid  input  1  SHALL indicate line_width/pic_height are valid.
REQ-009 blk_ready  input  1  SHALL be the downstream (DCT) acceptance signal.
REQ-010 blk_valid  output  1  SHALL flag a valid blk_data sample.
REQ-011 blk_data  output  8  SHALL be the block sample, row-major within an 8x8 block.
REQ-012 blk_comp  output  2  SHALL give the component of the current block: 0=Y, 1=Cb, 2=Cr.
REQ-013 blk_first / blk_last  output  1 each  SHALL mark sample 0 / sample 63 of each block.
REQ-014 frame_done  output  1  SHALL pulse one cycle after the last sample of the picture is accepted.
REQ-015 overflow  output  1  SHALL be a sticky flag for dropped input samples.

Function
REQ-016 Dimensions SHALL be latched on the first cycle dimensions_valid is high while the write side is idle; d_qual before that SHALL be ignored.
REQ-017 Storage SHALL be two strip banks (ping-pong), each 3 components x 8 rows x MAX_WIDTH bytes.
REQ-018 Write side SHALL count component (0..2), column, and row-in-strip; a sample SHALL be written to bank[wbank][comp][row][col] on each d_qual.
REQ-019 Columns >= MAX_WIDTH SHALL be discarded without advancing the row until the column count reaches line_width.
REQ-020 A bank SHALL become full after 8 rows or after the last picture line, and the write side SHALL then toggle wbank.
REQ-021 If d_qual arrives while the target bank is still full (not drained), the sample SHALL be dropped and overflow set.
REQ-022 Read FSM states: IDLE, LOAD, EMIT, DONE. IDLE->LOAD when either bank is full (lower index first if both); LOAD primes the registered memory read; EMIT streams; DONE frees the bank.
REQ-023 Emission order within a strip: for block column bx=0..ceil(W/8)-1, blocks comp 0,1,2, each 64 samples with row 0..7, col 0..7.
REQ-024 blk_valid SHALL rise no earlier than 2 cycles after a bank becomes full; blk_data, blk_comp, blk_first and blk_last SHALL hold stable while blk_valid=1 and blk_ready=0.
REQ-025 A sample transfers when blk_valid and blk_ready are both 1; sustained throughput SHALL be one sample per cycle.
REQ-026 DONE SHALL release the bank in one cycle; if it was the last strip, it SHALL pulse frame_done, clear the latched dimensions, and return to IDLE.
REQ-027 Write into a bank and read of the other bank in the same cycle SHALL proceed independently.

Reset
REQ-028 While rst=1: blk_valid, blk_data, blk_comp, blk_first, blk_last, frame_done and overflow SHALL be 0; both banks empty; all counters 0; FSM in IDLE; wbank=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; memory contents need not clear.

Configuration
REQ-030 With BLOCK_FORMER_PAD_EN defined, partial blocks (W or H not a multiple of 8) SHALL be padded by replicating the last valid column and the last valid row.
REQ-031 Without BLOCK_FORMER_PAD_EN, partial block columns SHALL be skipped, and a final partial strip SHALL be released without emission (frame_done still pulses).

Verification
REQ-032 8x8 picture, Y=n, Cb=n+64, Cr=n+128 for pixel n, blk_ready=1 -> 192 samples: Y 0..63, then 64..127, then 128..191; blk_first at samples 0/64/128; frame_done once.
REQ-033 16x16 picture, blk_ready toggling every cycle -> 12 blocks in strip/bx/comp order, data stable during stalls, overflow=0.
REQ-034 12x10 picture with PAD_EN, Y=column index -> block bx=1 rows hold 8,9,10,11,11,11,11,11; strip 1 rows 2..7 repeat row 1.
REQ-035 Same 12x10 picture without PAD_EN -> only bx=0 of strip 0 emitted (3 blocks); frame_done pulses.
REQ-036 blk_ready=0 throughout a 16x24 input -> third strip is dropped, overflow=1 and stays set until rst.
REQ-037 rst pulsed after 100 samples of an 8x8 frame -> all outputs 0; a new 8x8 frame then emits correctly.

Source files
------------

// File: rtl/block_former.sv
// rtl/block_former.sv - raster YCbCr samples to 8x8 blocks through ping-pong strip banks
// Optional feature: define BLOCK_FORMER_PAD_EN to pad partial blocks by edge replication.
module block_former #(
  parameter int MAX_WIDTH = 640
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        d_qual,
  input  logic [7:0]  d_in,
  input  logic [31:0] line_width,
  input  logic [31:0] pic_height,
  input  logic        dimensions_valid,
  input  logic        blk_ready,
  output logic        blk_valid,
  output logic [7:0]  blk_data,
  output logic [1:0]  blk_comp,
  output logic        blk_first,
  output logic        blk_last,
  output logic        frame_done,
  output logic        overflow
);

  localparam int DEPTH = 2 * 3 * 8 * MAX_WIDTH;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    mem_rdata_q;

  logic          dims_q, dims_d;
  logic [31:0]   width_q, width_d, height_q, height_d;
  logic [1:0]    wcomp_q, wcomp_d;
  logic [31:0]   wcol_q, wcol_d, wline_q, wline_d;
  logic [2:0]    wrow_q, wrow_d;
  logic          wbank_q, wbank_d;
  logic          overflow_q, overflow_d;
  logic          we;
  logic [AW-1:0] waddr;

  logic [1:0]    full_q, full_d, last_q, last_d;
  logic [3:0]    rows_q [2];
  logic [3:0]    rows_d [2];

  state_t        state_q, state_d;
  logic          rbank_q, rbank_d;
  logic [31:0]   bx_q, bx_d;
  logic [1:0]    rcomp_q, rcomp_d;
  logic [2:0]    r_q, r_d, c_q, c_d;
  logic          valid_q, valid_d, frame_done_q, frame_done_d;
  logic [AW-1:0] raddr;
  logic [31:0]   weff, nbx, scol;
  logic [3:0]    srows;
  logic [2:0]    srow;
  logic          skip, last_pos;

  function automatic logic [AW-1:0] addr_of(input logic bank, input logic [1:0] comp,
                                             input logic [2:0] row, input logic [31:0] col);
    return AW'(((32'(bank) * 32'd3 + 32'(comp)) * 32'd8 + 32'(row)) * 32'(MAX_WIDTH) + col);
  endfunction

  always_comb begin
    dims_d       = dims_q;
    width_d      = width_q;
    height_d     = height_q;
    wcomp_d      = wcomp_q;
    wcol_d       = wcol_q;
    wline_d      = wline_q;
    wrow_d       = wrow_q;
    wbank_d      = wbank_q;
    overflow_d   = overflow_q;
    full_d       = full_q;
    last_d       = last_q;
    rows_d       = rows_q;
    state_d      = state_q;
    rbank_d      = rbank_q;
    bx_d         = bx_q;
    rcomp_d      = rcomp_q;
    r_d          = r_q;
    c_d          = c_q;
    valid_d      = valid_q;
    frame_done_d = 1'b0;
    we           = 1'b0;
    waddr        = addr_of(wbank_q, wcomp_q, wrow_q, wcol_q);

    // Geometry of the strip held in the bank being read
    weff  = (width_q > 32'(MAX_WIDTH)) ? 32'(MAX_WIDTH) : width_q;
    srows = rows_q[rbank_q];
`ifdef BLOCK_FORMER_PAD_EN
    nbx  = (weff + 32'd7) >> 3;
    skip = (nbx == 32'd0);
`else
    nbx  = weff >> 3;
    skip = (nbx == 32'd0) || (srows != 4'd8);
`endif
    last_pos = (bx_q + 32'd1 == nbx) && (rcomp_q == 2'd2) && (r_q == 3'd7) && (c_q == 3'd7);

    if (!dims_q) begin
      if (dimensions_valid) begin
        dims_d   = 1'b1;
        width_d  = line_width;
        height_d = pic_height;
      end
    end else if (d_qual && (wline_q < height_q)) begin
      if (full_q[wbank_q]) begin
        overflow_d = 1'b1;
      end else begin
        we = (wcol_q < 32'(MAX_WIDTH));
        if (wcomp_q != 2'd2) begin
          wcomp_d = wcomp_q + 2'd1;
        end else begin
          wcomp_d = 2'd0;
          if (wcol_q + 32'd1 != width_q) begin
            wcol_d = wcol_q + 32'd1;
          end else begin
            wcol_d  = 32'd0;
            wline_d = wline_q + 32'd1;
            wrow_d  = wrow_q + 3'd1;
            if ((wrow_q == 3'd7) || (wline_q + 32'd1 == height_q)) begin
              full_d[wbank_q] = 1'b1;
              last_d[wbank_q] = (wline_q + 32'd1 == height_q);
              rows_d[wbank_q] = {1'b0, wrow_q} + 4'd1;
              wbank_d         = ~wbank_q;
              wrow_d          = 3'd0;
            end
          end
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (full_q[0] || full_q[1]) begin
          rbank_d = full_q[0] ? 1'b0 : 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (skip) begin
          state_d      = DONE;
          frame_done_d = last_q[rbank_q];
        end else begin
          state_d = EMIT;
          valid_d = 1'b1;
        end
      end
      EMIT: begin
        if (blk_ready) begin
          if (last_pos) begin
            state_d      = DONE;
            valid_d      = 1'b0;
            frame_done_d = last_q[rbank_q];
          end else begin
            c_d = c_q + 3'd1;
            if (c_q == 3'd7) begin
              r_d = r_q + 3'd1;
              if (r_q == 3'd7) begin
                if (rcomp_q == 2'd2) begin
                  rcomp_d = 2'd0;
                  bx_d    = bx_q + 32'd1;
                end else begin
                  rcomp_d = rcomp_q + 2'd1;
                end
              end
            end
          end
        end
      end
      DONE: begin
        full_d[rbank_q] = 1'b0;
        state_d         = IDLE;
        bx_d            = 32'd0;
        rcomp_d         = 2'd0;
        r_d             = 3'd0;
        c_d             = 3'd0;
        if (last_q[rbank_q]) begin
          dims_d  = 1'b0;
          wline_d = 32'd0;
          wcol_d  = 32'd0;
          wrow_d  = 3'd0;
          wcomp_d = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Address the sample that will be presented next cycle; a stall re-reads the current one
`ifdef BLOCK_FORMER_PAD_EN
    scol = (((bx_d << 3) + 32'(c_d)) >= weff) ? (weff - 32'd1) : ((bx_d << 3) + 32'(c_d));
    srow = ({1'b0, r_d} >= srows) ? 3'(srows - 4'd1) : r_d;
`else
    scol = (bx_d << 3) + 32'(c_d);
    srow = r_d;
`endif
    raddr = addr_of(rbank_q, rcomp_d, srow, scol);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      dims_q       <= 1'b0;
      width_q      <= '0;
      height_q     <= '0;
      wcomp_q      <= '0;
      wcol_q       <= '0;
      wline_q      <= '0;
      wrow_q       <= '0;
      wbank_q      <= 1'b0;
      overflow_q   <= 1'b0;
      full_q       <= '0;
      last_q       <= '0;
      rows_q[0]    <= '0;
      rows_q[1]    <= '0;
      state_q      <= IDLE;
      rbank_q      <= 1'b0;
      bx_q         <= '0;
      rcomp_q      <= '0;
      r_q          <= '0;
      c_q          <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      dims_q       <= dims_d;
      width_q      <= width_d;
      height_q     <= height_d;
      wcomp_q      <= wcomp_d;
      wcol_q       <= wcol_d;
      wline_q      <= wline_d;
      wrow_q       <= wrow_d;
      wbank_q      <= wbank_d;
      overflow_q   <= overflow_d;
      full_q       <= full_d;
      last_q       <= last_d;
      rows_q       <= rows_d;
      state_q      <= state_d;
      rbank_q      <= rbank_d;
      bx_q         <= bx_d;
      rcomp_q      <= rcomp_d;
      r_q          <= r_d;
      c_q          <= c_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (we) begin
      mem[waddr] <= d_in;
    end
    mem_rdata_q <= mem[raddr];
  end

  assign blk_valid  = valid_q;
  assign blk_data   = valid_q ? mem_rdata_q : 8'd0;
  assign blk_comp   = valid_q ? rcomp_q : 2'd0;
  assign blk_first  = valid_q && (r_q == 3'd0) && (c_q == 3'd0);
  assign blk_last   = valid_q && (r_q == 3'd7) && (c_q == 3'd7);
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_block_former.sv
// tb/tb_block_former.sv - randomized self-checking bench for block_former against a block-order model
module tb_block_former;
  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        d_qual = 1'b0;
  logic [7:0]  d_in = 8'd0;
  logic [31:0] line_width = 32'd0;
  logic [31:0] pic_height = 32'd0;
  logic        dimensions_valid = 1'b0;
  logic        blk_ready = 1'b0;
  logic        blk_valid, blk_first, blk_last, frame_done, overflow;
  logic [7:0]  blk_data;
  logic [1:0]  blk_comp;

  int checks = 0;
  int errors = 0;

  block_former dut (
    .clk_in(clk_in), .rst(rst), .d_qual(d_qual), .d_in(d_in),
    .line_width(line_width), .pic_height(pic_height), .dimensions_valid(dimensions_valid),
    .blk_ready(blk_ready), .blk_valid(blk_valid), .blk_data(blk_data), .blk_comp(blk_comp),
    .blk_first(blk_first), .blk_last(blk_last), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0] data;
    logic [1:0] comp;
    logic       first;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       got;
  logic [7:0] pix [3][4096];
  logic [7:0] rx_data [4096];
  logic       rx_first [4096];
  logic [1:0] rx_comp [4096];
  int         rx_n = 0;
  int         fd_count = 0;
  int         rdy_mode = 0;
  int         in_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_in); #1;
      case (rdy_mode)
        0: blk_ready = 1'b1;
        1: blk_ready = ~blk_ready;
        2: blk_ready = ($urandom_range(3) != 0);
        default: blk_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard: every transfer against the model, plus hold-during-stall
  logic       pv = 1'b0, pr = 1'b0, pf = 1'b0, pl = 1'b0;
  logic [7:0] pd = 8'd0;
  logic [1:0] pc = 2'd0;
  always @(negedge clk_in) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr)
        check("stall_hold", 32'({blk_valid, blk_data, blk_comp, blk_first, blk_last}),
              32'({1'b1, pd, pc, pf, pl}));
      if (blk_valid && blk_ready) begin
        if (rx_n < 4096) begin
          rx_data[rx_n] = blk_data;
          rx_first[rx_n] = blk_first;
          rx_comp[rx_n] = blk_comp;
        end
        rx_n++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample actual=%0h required=none", blk_data);
        end else begin
          got = exp_q.pop_front();
          check("sample", 32'({blk_data, blk_comp, blk_first, blk_last}),
                32'({got.data, got.comp, got.first, got.last}));
        end
      end
      if (frame_done) begin
        fd_count++;
        check("fd_after_last", 32'(exp_q.size()), 32'd0);
      end
      pv = blk_valid; pr = blk_ready; pd = blk_data; pc = blk_comp; pf = blk_first; pl = blk_last;
    end
  end

  task automatic fill(input int w, input int h, input int pattern);
    for (int n = 0; n < w * h; n++) begin
      case (pattern)
        0: begin
          pix[0][n] = 8'(n); pix[1][n] = 8'(n + 64); pix[2][n] = 8'(n + 128);
        end
        1: begin
          pix[0][n] = 8'(n % w); pix[1][n] = 8'((n / w) * 10); pix[2][n] = 8'($urandom);
        end
        default: begin
          pix[0][n] = 8'($urandom); pix[1][n] = 8'($urandom); pix[2][n] = 8'($urandom);
        end
      endcase
    end
  endtask

  // Expected stream: strips, then block columns, then Y/Cb/Cr, then 8x8 raster
  task automatic build_model(input int w, input int h);
    int nbx, rows, col, row;
    exp_t e;
    for (int s = 0; s < (h + 7) / 8; s++) begin
      rows = (h - 8 * s < 8) ? h - 8 * s : 8;
`ifdef BLOCK_FORMER_PAD_EN
      nbx = (w + 7) / 8;
`else
      nbx = (rows == 8) ? w / 8 : 0;
`endif
      for (int bx = 0; bx < nbx; bx++)
        for (int cp = 0; cp < 3; cp++)
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
              col = bx * 8 + c;
              if (col > w - 1) col = w - 1;
              row = s * 8 + ((r < rows) ? r : rows - 1);
              e.data = pix[cp][row * w + col];
              e.comp = 2'(cp);
              e.first = (r == 0) && (c == 0);
              e.last = (r == 7) && (c == 7);
              exp_q.push_back(e);
            end
    end
  endtask

  task automatic start_dims(input int w, input int h);
    @(posedge clk_in); #1;
    line_width = 32'(w); pic_height = 32'(h); dimensions_valid = 1'b1;
    @(posedge clk_in); #1;
    dimensions_valid = 1'b0;
  endtask

  task automatic feed(input int w, input int h, input int nmax);
    int k = 0;
    for (int n = 0; n < w * h; n++)
      for (int c = 0; c < 3; c++) begin
        if (k < nmax) begin
          if (in_gap > 0)
            while ($urandom_range(in_gap - 1) != 0) begin
              d_qual = 1'b0; @(posedge clk_in); #1;
            end
          d_qual = 1'b1; d_in = pix[c][n]; k++;
          @(posedge clk_in); #1;
        end
      end
    d_qual = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int pattern, input string name);
    int fd0, cyc;
    fill(w, h, pattern);
    build_model(w, h);
    rx_n = 0;
    fd0 = fd_count;
    start_dims(w, h);
    feed(w, h, w * h * 3);
    cyc = 0;
    while ((exp_q.size() != 0 || fd_count == fd0) && cyc < 30000) begin
      @(posedge clk_in); cyc++;
    end
    check({name, "_complete"}, 32'(cyc < 30000), 32'd1);
    exp_q.delete();
    repeat (3) @(posedge clk_in);
    #1;
    check({name, "_frame_done_once"}, 32'(fd_count - fd0), 32'd1);
  endtask

  logic [7:0] pad_row [8];

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_outputs", 32'({blk_valid, blk_data, blk_comp, blk_first, blk_last, frame_done, overflow}), 32'd0);
    rst = 1'b0;
    d_qual = 1'b1; d_in = 8'hAA;
    repeat (5) @(posedge clk_in);
    #1;
    d_qual = 1'b0;

    rdy_mode = 0; in_gap = 0;
    run_frame(8, 8, 0, "f8x8");
    check("f8x8_count", 32'(rx_n), 32'd192);
    check("f8x8_s0", 32'(rx_data[0]), 32'd0);
    check("f8x8_s63", 32'(rx_data[63]), 32'd63);
    check("f8x8_s64", 32'(rx_data[64]), 32'd64);
    check("f8x8_s128", 32'(rx_data[128]), 32'd128);
    check("f8x8_s191", 32'(rx_data[191]), 32'd191);
    check("f8x8_first", 32'({rx_first[0], rx_first[1], rx_first[64], rx_first[128]}), 32'b1011);
    check("f8x8_comp", 32'({rx_comp[63], rx_comp[64], rx_comp[191]}), 32'b00_01_10);

    rdy_mode = 1;
    run_frame(16, 16, 2, "f16x16");
    check("f16x16_count", 32'(rx_n), 32'd768);
    check("f16x16_overflow", 32'(overflow), 32'd0);

    rdy_mode = 0;
    run_frame(12, 10, 1, "f12x10");
`ifdef BLOCK_FORMER_PAD_EN
    pad_row = '{8'd8, 8'd9, 8'd10, 8'd11, 8'd11, 8'd11, 8'd11, 8'd11};
    check("f12x10_count", 32'(rx_n), 32'd768);
    for (int i = 0; i < 8; i++) check("f12x10_padcol", 32'(rx_data[192 + i]), 32'(pad_row[i]));
    check("f12x10_row8", 32'(rx_data[448]), 32'd80);
    for (int r = 2; r < 8; r++) check("f12x10_padrow", 32'(rx_data[448 + 8 * r]), 32'd90);
`else
    check("f12x10_count", 32'(rx_n), 32'd192);
    check("f12x10_y7", 32'(rx_data[7]), 32'd7);
    check("f12x10_cb_row7", 32'(rx_data[64 + 56]), 32'd70);
`endif

    // Downstream never ready: third strip has nowhere to go
    rdy_mode = 3;
    fill(16, 24, 2);
    start_dims(16, 24);
    feed(16, 24, 16 * 24 * 3);
    repeat (5) @(posedge clk_in);
    #1;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_head", 32'({blk_valid, blk_data, blk_comp, blk_first}), 32'({1'b1, pix[0][0], 2'd0, 1'b1}));
    repeat (20) @(posedge clk_in);
    #1;
    check("ovf_sticky", 32'(overflow), 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset", 32'({blk_valid, blk_data, blk_first, overflow}), 32'd0);
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b0;

    // Abandon a frame part-way through
    rdy_mode = 0;
    fill(8, 8, 2);
    start_dims(8, 8);
    feed(8, 8, 100);
    rst = 1'b1;
    #1;
    check("midframe_reset", 32'({blk_valid, blk_data, blk_comp, blk_first, blk_last, frame_done, overflow}), 32'd0);
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b0;
    run_frame(8, 8, 0, "after_reset");
    check("after_reset_count", 32'(rx_n), 32'd192);

    rdy_mode = 2; in_gap = 3;
    for (int i = 0; i < 6; i++)
      run_frame($urandom_range(8, 32), $urandom_range(1, 17), 2, "random");
    check("random_overflow", 32'(overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
